multicycle_ctrl: RTL

Multi-cycle control FSM that sequences the shared 32-bit ALU, PC, instruction register, register file and memory port of the single-ALU datapath. It decodes the latched opcode/funct and, each cycle, drives ALU control, operand-mux selects and write strobes. It also stalls on a memory ready handshake, flags unsupported opcodes and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM for the single-ALU datapath
module multicycle_ctrl #(
  parameter logic [3:0] ADD_CODE = 4'b0010,
  parameter logic [3:0] SUB_CODE = 4'b0110,
  parameter logic [3:0] NOP_CODE = 4'b1111
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EX_R, EX_ADDR, EX_BR, EX_J, MEM_RD, MEM_WR, WB_ALU, WB_MEM
  } state_t;

  state_t state, state_nx;
  logic   retire;
  logic   bad_op;

  always_comb begin
    state_nx = state;
    bad_op   = 1'b0;
    case (state)
      IDLE:    state_nx = FETCH;
      FETCH:   state_nx = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_R: begin
            if (funct == FN_ADD) state_nx = EX_R;
            else begin
              state_nx = FETCH;
              bad_op   = 1'b1;
            end
          end
          OP_ADDI, OP_LW, OP_SW: state_nx = EX_ADDR;
          OP_BEQ:                state_nx = EX_BR;
          OP_J:                  state_nx = EX_J;
          default: begin
            state_nx = FETCH;
            bad_op   = 1'b1;
          end
        endcase
      end
      EX_R:    state_nx = WB_ALU;
      EX_ADDR: state_nx = (opcode == OP_LW) ? MEM_RD : (opcode == OP_SW) ? MEM_WR : WB_ALU;
      EX_BR:   state_nx = FETCH;
      EX_J:    state_nx = FETCH;
      MEM_RD:  state_nx = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:  state_nx = mem_ready ? FETCH : MEM_WR;
      WB_ALU:  state_nx = FETCH;
      WB_MEM:  state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
  end

  assign retire = (state == EX_BR) || (state == EX_J) || (state == WB_ALU) ||
                  (state == WB_MEM) || ((state == MEM_WR) && mem_ready);

  // The PC/IR strobes depend on same-cycle inputs, so they stay combinational.
  assign ir_write = (state == FETCH) && mem_ready;
  assign pc_write = ((state == FETCH) && mem_ready) || ((state == EX_BR) && zero) ||
                    (state == EX_J);

  // Moore outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      alu_ctrl   <= NOP_CODE;
      alu_src_a  <= 1'b0;
      alu_src_b  <= 2'b00;
      pc_src     <= 2'b00;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      i_or_d     <= 1'b0;
      reg_write  <= 1'b0;
      reg_dst    <= 1'b0;
      mem_to_reg <= 1'b0;
      illegal    <= 1'b0;
      retired    <= 32'd0;
    end else begin
      state      <= state_nx;
      alu_ctrl   <= NOP_CODE;
      alu_src_a  <= 1'b0;
      alu_src_b  <= 2'b00;
      pc_src     <= 2'b00;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      i_or_d     <= 1'b0;
      reg_write  <= 1'b0;
      reg_dst    <= 1'b0;
      mem_to_reg <= 1'b0;
      if (bad_op) illegal <= 1'b1;
      if (retire) retired <= retired + 32'd1;
      case (state_nx)
        FETCH: begin
          mem_read  <= 1'b1;
          alu_src_b <= 2'b01;
          alu_ctrl  <= ADD_CODE;
        end
        DECODE: begin
          alu_src_b <= 2'b11;
          alu_ctrl  <= ADD_CODE;
        end
        EX_R: begin
          alu_src_a <= 1'b1;
          alu_ctrl  <= ADD_CODE;
        end
        EX_ADDR: begin
          alu_src_a <= 1'b1;
          alu_src_b <= 2'b10;
          alu_ctrl  <= ADD_CODE;
        end
        EX_BR: begin
          alu_src_a <= 1'b1;
          alu_ctrl  <= SUB_CODE;
          pc_src    <= 2'b01;
        end
        EX_J:   pc_src <= 2'b10;
        MEM_RD: begin
          mem_read <= 1'b1;
          i_or_d   <= 1'b1;
        end
        MEM_WR: begin
          mem_write <= 1'b1;
          i_or_d    <= 1'b1;
        end
        WB_ALU: begin
          reg_write <= 1'b1;
          reg_dst   <= (opcode == OP_R);
        end
        WB_MEM: begin
          reg_write  <= 1'b1;
          mem_to_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
